msk_g4mul_hpc1_feeder: RTL and testbench

- Upstream issue stage for the masked GF(4) HPC1 multiplier.
- Accepts shared operands through a valid/ready handshake and buffers fresh randomness from the PRNG in a 2-entry FIFO.
- Drives each gadget input port at its required latency and captures the gadget result, so callers see a plain pipelined masked multiply.
- Throughput is one operation per cycle; the gadget is instantiated externally and wired to the g_* ports.

---
 rtl/msk_g4mul_hpc1_feeder.sv | 162 ++++++++++++++++
 tb/tb_msk_g4mul_hpc1_feeder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/msk_g4mul_hpc1_feeder.sv
// Issue stage for the masked GF(4) HPC1 multiplier.
// Buffers PRNG words in a 2-entry FIFO, accepts shared operands and drives each
// gadget port at its own latency, then captures the gadget result so the caller
// sees a plain pipelined masked multiply. The gadget itself lives outside.
module msk_g4mul_hpc1_feeder #(
  parameter  int d          = 2,
  parameter  int REF_RNDLAT = 0,
  parameter  int REF_N_RND  = 1,
  parameter  int DOM_RND    = 1,
  localparam int RND_W      = 2*(REF_N_RND+DOM_RND)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [d-1:0]     in_a0,
  input  logic [d-1:0]     in_a1,
  input  logic [d-1:0]     in_b0,
  input  logic [d-1:0]     in_b1,
  input  logic             rnd_in_valid,
  output logic             rnd_in_ready,
  input  logic [RND_W-1:0] rnd_in,
  output logic [d-1:0]     g_ina0,
  output logic [d-1:0]     g_ina1,
  output logic [d-1:0]     g_inb0,
  output logic [d-1:0]     g_inb1,
  output logic [RND_W-1:0] g_rnd,
  input  logic [d-1:0]     g_out0,
  input  logic [d-1:0]     g_out1,
  output logic [d-1:0]     res0,
  output logic [d-1:0]     res1,
  output logic             res_valid,
  output logic             busy
);

  localparam int L  = REF_RNDLAT;
  localparam int RW = 2*REF_N_RND;    // refresh slice of a word
  localparam int MW = RND_W - RW;     // multiply slice of a word
  localparam int NV = L + 3;          // gadget cycles 0 .. 2+L

  // FIFO occupancy, one-hot
  typedef enum logic [2:0] {
    F_EMPTY = 3'b001,
    F_ONE   = 3'b010,
    F_FULL  = 3'b100
  } fst_e;

  fst_e                   fst_q, fst_d;
  logic [1:0][RND_W-1:0]  mem_q, mem_d;   // entry 0 is always the head
  logic                   pop, push;

  assign pop  = in_valid & in_ready;
  // a pop frees the slot in the same cycle, so a full FIFO can still take a word
  assign push = rnd_in_valid & (rnd_in_ready | pop);

  // FIFO state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fst_q <= F_EMPTY;
      mem_q <= '0;
    end else begin
      fst_q <= fst_d;
      mem_q <= mem_d;
    end
  end

  // FIFO next state: shift toward the head on pop, append on push
  always_comb begin
    fst_d = fst_q;
    mem_d = mem_q;
    case (fst_q)
      F_EMPTY: begin
        if (push) begin
          mem_d[0] = rnd_in;
          fst_d    = F_ONE;
        end
      end
      F_ONE: begin
        if (push && pop) begin
          mem_d[0] = rnd_in;
        end else if (push) begin
          mem_d[1] = rnd_in;
          fst_d    = F_FULL;
        end else if (pop) begin
          fst_d    = F_EMPTY;
        end
      end
      F_FULL: begin
        if (pop) begin
          mem_d[0] = mem_q[1];
          if (push) mem_d[1] = rnd_in;
          else      fst_d    = F_ONE;
        end
      end
      default: fst_d = F_EMPTY;
    endcase
  end

  // FIFO handshake outputs depend on occupancy only
  always_comb begin
    in_ready     = ~fst_q[0];
    rnd_in_ready = ~fst_q[2];
  end

  // Per-field delay lines. Each line loads zero when no op is accepted, so an
  // idle slot is all-zero and every gadget port is driven straight from a
  // register with no logic mixing the shares.
  logic [NV-1:0]          vld_q;
  logic [L+1:0][d-1:0]    a0_q, a1_q;
  logic [L:0][d-1:0]      b0_q, b1_q;
  logic [L+1:0][MW-1:0]   mul_q;
  logic [RW-1:0]          ref_q;
  logic [d-1:0]           res0_q, res1_q;
  logic                   rv_q;

  // operand/randomness pipeline and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      a0_q   <= '0;
      a1_q   <= '0;
      b0_q   <= '0;
      b1_q   <= '0;
      mul_q  <= '0;
      ref_q  <= '0;
      res0_q <= '0;
      res1_q <= '0;
      rv_q   <= 1'b0;
    end else begin
      vld_q    <= {vld_q[NV-2:0], pop};
      a0_q[0]  <= pop ? in_a0 : '0;
      a1_q[0]  <= pop ? in_a1 : '0;
      b0_q[0]  <= pop ? in_b0 : '0;
      b1_q[0]  <= pop ? in_b1 : '0;
      mul_q[0] <= pop ? mem_q[0][RND_W-1:RW] : '0;
      ref_q    <= pop ? mem_q[0][RW-1:0] : '0;
      for (int k = 1; k <= L+1; k++) begin
        a0_q[k]  <= a0_q[k-1];
        a1_q[k]  <= a1_q[k-1];
        mul_q[k] <= mul_q[k-1];
      end
      for (int k = 1; k <= L; k++) begin
        b0_q[k] <= b0_q[k-1];
        b1_q[k] <= b1_q[k-1];
      end
      rv_q   <= vld_q[L+2];
      res0_q <= vld_q[L+2] ? g_out0 : '0;
      res1_q <= vld_q[L+2] ? g_out1 : '0;
    end
  end

  assign g_rnd     = {mul_q[L+1], ref_q};
  assign g_inb0    = b0_q[L];
  assign g_inb1    = b1_q[L];
  assign g_ina0    = a0_q[L+1];
  assign g_ina1    = a1_q[L+1];
  assign res0      = res0_q;
  assign res1      = res1_q;
  assign res_valid = rv_q;
  assign busy      = (|vld_q) | rv_q;

endmodule

// File: tb/tb_msk_g4mul_hpc1_feeder.sv
// Bench for msk_g4mul_hpc1_feeder: two builds (REF_RNDLAT 0 and 1) share one
// stimulus stream; each has a behavioural gadget stub. A cycle-indexed
// schedule of expected port values, built from the latency rules, is compared
// against both builds every cycle.
module tb_msk_g4mul_hpc1_feeder;

  logic       clk;
  logic       rst_n;
  logic       in_valid, rnd_in_valid;
  logic [1:0] in_a0, in_a1, in_b0, in_b1;
  logic [3:0] rnd_in;

  logic       in_ready_w [2];
  logic       rnd_in_ready_w [2];
  logic       res_valid_w [2];
  logic       busy_w [2];
  logic [1:0] ina0_w [2], ina1_w [2], inb0_w [2], inb1_w [2];
  logic [1:0] res0_w [2], res1_w [2], gout0_w [2], gout1_w [2];
  logic [3:0] grnd_w [2];

  function automatic logic [1:0] gmul(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] p;
    p[0] = (a[0] & b[0]) ^ (a[1] & b[1]);
    p[1] = (a[1] & b[0]) ^ (a[0] & b[1]) ^ (a[1] & b[1]);
    return p;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    logic [1:0] bd, go0, go1, p_w;

    msk_g4mul_hpc1_feeder #(.d(2), .REF_RNDLAT(g), .REF_N_RND(1), .DOM_RND(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready_w[g]),
      .in_a0(in_a0), .in_a1(in_a1), .in_b0(in_b0), .in_b1(in_b1),
      .rnd_in_valid(rnd_in_valid), .rnd_in_ready(rnd_in_ready_w[g]), .rnd_in(rnd_in),
      .g_ina0(ina0_w[g]), .g_ina1(ina1_w[g]), .g_inb0(inb0_w[g]), .g_inb1(inb1_w[g]),
      .g_rnd(grnd_w[g]), .g_out0(gout0_w[g]), .g_out1(gout1_w[g]),
      .res0(res0_w[g]), .res1(res1_w[g]), .res_valid(res_valid_w[g]), .busy(busy_w[g])
    );

    // gadget stub: b seen one cycle before a, product one cycle after a, remasked
    assign p_w = gmul({^ina1_w[g], ^ina0_w[g]}, bd);
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        bd <= '0; go0 <= '0; go1 <= '0;
      end else begin
        bd  <= {^inb1_w[g], ^inb0_w[g]};
        go0 <= {grnd_w[g][2], p_w[0] ^ grnd_w[g][2]};
        go1 <= {grnd_w[g][3], p_w[1] ^ grnd_w[g][3]};
      end
    end
    assign gout0_w[g] = go0;
    assign gout1_w[g] = go1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected schedule, indexed [lane][cycle % 16]
  logic [1:0] e_ref [2][16], e_mul [2][16], e_res [2][16];
  logic [1:0] e_ina0 [2][16], e_ina1 [2][16], e_inb0 [2][16], e_inb1 [2][16];
  logic       e_rv [2][16], e_busy [2][16];
  logic [3:0] q [$];
  int         cyc = 0;
  int         n_chk = 0, n_fail = 0;
  logic       acc, psh;
  logic [3:0] w;

  // literal pins written by the stimulus: lane, cycle and required product
  int         pin_l [16], pin_c [16];
  logic [1:0] pin_v [16];
  int         pin_n = 0;

  task automatic chk(input string nm, input int l, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s lane%0d cyc%0d: got %0h expected %0h", nm, l, cyc, act, exp);
    end
  endtask

  task automatic clr_slot(input int s);
    for (int l = 0; l < 2; l++) begin
      e_ref[l][s] = '0; e_mul[l][s] = '0; e_res[l][s] = '0;
      e_ina0[l][s] = '0; e_ina1[l][s] = '0; e_inb0[l][s] = '0; e_inb1[l][s] = '0;
      e_rv[l][s] = 1'b0; e_busy[l][s] = 1'b0;
    end
  endtask

  // accepted in cycle c: refresh bits at c+1, b at c+1+L, a and multiply bits
  // at c+2+L, result valid at c+4+L, busy over c+1 .. c+4+L
  task automatic sched(input int c, input logic [3:0] wd, input logic [1:0] a0, a1, b0, b1);
    logic [1:0] prod;
    prod = gmul({^a1, ^a0}, {^b1, ^b0});
    for (int l = 0; l < 2; l++) begin
      e_ref[l][(c+1)%16]    = wd[1:0];
      e_inb0[l][(c+1+l)%16] = b0;
      e_inb1[l][(c+1+l)%16] = b1;
      e_ina0[l][(c+2+l)%16] = a0;
      e_ina1[l][(c+2+l)%16] = a1;
      e_mul[l][(c+2+l)%16]  = wd[3:2];
      e_rv[l][(c+4+l)%16]   = 1'b1;
      e_res[l][(c+4+l)%16]  = prod;
      for (int k = 1; k <= 4+l; k++) e_busy[l][(c+k)%16] = 1'b1;
    end
  endtask

  // single compare process: model state advances on every checked cycle
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      #1;
      q.delete();
      for (int s = 0; s < 16; s++) clr_slot(s);
      for (int l = 0; l < 2; l++) begin
        chk("rst_in_ready", l, 32'(in_ready_w[l]), 32'd0);
        chk("rst_rnd_in_ready", l, 32'(rnd_in_ready_w[l]), 32'd1);
        chk("rst_g_ports", l, {20'd0, grnd_w[l], ina0_w[l], ina1_w[l], inb0_w[l], inb1_w[l]}, 32'd0);
        chk("rst_res", l, {27'd0, res_valid_w[l], res0_w[l], res1_w[l]}, 32'd0);
        chk("rst_busy", l, 32'(busy_w[l]), 32'd0);
      end
    end else begin
      for (int l = 0; l < 2; l++) begin
        int s;
        s = cyc % 16;
        chk("in_ready", l, 32'(in_ready_w[l]), 32'(q.size() > 0));
        chk("rnd_in_ready", l, 32'(rnd_in_ready_w[l]), 32'(q.size() < 2));
        chk("g_rnd", l, 32'(grnd_w[l]), 32'({e_mul[l][s], e_ref[l][s]}));
        chk("g_inb", l, 32'({inb1_w[l], inb0_w[l]}), 32'({e_inb1[l][s], e_inb0[l][s]}));
        chk("g_ina", l, 32'({ina1_w[l], ina0_w[l]}), 32'({e_ina1[l][s], e_ina0[l][s]}));
        chk("res_valid", l, 32'(res_valid_w[l]), 32'(e_rv[l][s]));
        if (e_rv[l][s]) chk("res", l, 32'({^res1_w[l], ^res0_w[l]}), 32'(e_res[l][s]));
        else            chk("res_idle", l, 32'({res1_w[l], res0_w[l]}), 32'd0);
        chk("busy", l, 32'(busy_w[l]), 32'(e_busy[l][s]));
      end
      for (int k = 0; k < pin_n; k++) begin
        if (pin_c[k] == cyc) begin
          chk("pin_valid", pin_l[k], 32'(res_valid_w[pin_l[k]]), 32'd1);
          chk("pin_res", pin_l[k], 32'({^res1_w[pin_l[k]], ^res0_w[pin_l[k]]}), 32'(pin_v[k]));
        end
      end
      acc = in_valid && (q.size() > 0);
      psh = rnd_in_valid && ((q.size() < 2) || acc);
      if (acc) begin
        w = q.pop_front();
        sched(cyc, w, in_a0, in_a1, in_b0, in_b1);
      end
      if (psh) q.push_back(rnd_in);
      clr_slot(cyc % 16);
      cyc++;
    end
  end

  task automatic drive(input bit iv, input bit rv, input logic [1:0] a, input logic [1:0] b, input logic [3:0] wd);
    logic [31:0] r;
    @(posedge clk);
    #1;
    r = $urandom;
    in_valid     = iv;
    in_a0        = {r[0], a[0] ^ r[0]};
    in_a1        = {r[1], a[1] ^ r[1]};
    in_b0        = {r[2], b[0] ^ r[2]};
    in_b1        = {r[3], b[1] ^ r[3]};
    rnd_in_valid = rv;
    rnd_in       = wd;
  endtask

  task automatic pin_add(input int l, input int c, input logic [1:0] v);
    if (pin_n < 16) begin
      pin_l[pin_n] = l; pin_c[pin_n] = c; pin_v[pin_n] = v;
      pin_n++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 2'd0, 2'd0, 4'h0);
  endtask

  int c0;

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; rnd_in_valid = 1'b0;
    in_a0 = '0; in_a1 = '0; in_b0 = '0; in_b1 = '0; rnd_in = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // single op 1*3 with one preloaded word
    drive(1'b0, 1'b1, 2'd0, 2'd0, 4'hA);
    drive(1'b1, 1'b0, 2'd1, 2'd3, 4'h0);
    c0 = cyc;
    pin_add(0, c0+4, 2'd3);
    pin_add(1, c0+5, 2'd3);
    idle(6);

    // three back-to-back ops, FIFO refilled every cycle
    drive(1'b0, 1'b1, 2'd0, 2'd0, 4'h5);
    drive(1'b1, 1'b1, 2'd2, 2'd2, 4'h6);
    c0 = cyc;
    drive(1'b1, 1'b1, 2'd2, 2'd3, 4'h9);
    drive(1'b1, 1'b1, 2'd3, 2'd3, 4'hC);
    pin_add(0, c0+4, 2'd3); pin_add(0, c0+5, 2'd1); pin_add(0, c0+6, 2'd2);
    pin_add(1, c0+5, 2'd3); pin_add(1, c0+6, 2'd1); pin_add(1, c0+7, 2'd2);
    drive(1'b1, 1'b0, 2'd1, 2'd1, 4'h0);   // drains the leftover word
    idle(6);

    // starvation: operand waiting, no randomness
    repeat (4) drive(1'b1, 1'b0, 2'd2, 2'd2, 4'h0);
    drive(1'b1, 1'b1, 2'd2, 2'd2, 4'h3);
    c0 = cyc;
    drive(1'b1, 1'b0, 2'd2, 2'd2, 4'h0);
    pin_add(0, c0+5, 2'd3);
    idle(6);

    // fill the FIFO, then push and pop together while full
    drive(1'b0, 1'b1, 2'd0, 2'd0, 4'h1);
    drive(1'b0, 1'b1, 2'd0, 2'd0, 4'h2);
    drive(1'b0, 1'b0, 2'd0, 2'd0, 4'h0);
    drive(1'b1, 1'b1, 2'd1, 2'd2, 4'h7);
    drive(1'b1, 1'b1, 2'd3, 2'd1, 4'hE);
    drive(1'b1, 1'b0, 2'd2, 2'd1, 4'h0);
    drive(1'b1, 1'b0, 2'd3, 2'd2, 4'h0);
    idle(8);

    // reset two cycles after an accept: the op must vanish
    drive(1'b0, 1'b1, 2'd0, 2'd0, 4'hB);
    drive(1'b1, 1'b0, 2'd3, 2'd2, 4'h0);
    drive(1'b0, 1'b0, 2'd0, 2'd0, 4'h0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) drive(1'b1, 1'b0, 2'd1, 2'd1, 4'h0);
    idle(4);

    // random traffic
    repeat (400) drive(($urandom % 4) != 0, ($urandom % 2) != 0,
                       2'($urandom), 2'($urandom), 4'($urandom));
    idle(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
